// File: rtl/spi_img_pkg.sv
// Shared definitions for the SPI image loader: command bytes, FSM state
// encoding, status byte layout and the MSB-first byte-to-pixel helper.
package spi_img_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'hA1;
  localparam logic [7:0] CMD_CLEAR = 8'hC3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } state_e;

  // status = {state[1:0], err_timeout, err_overrun, err_cmd, err_chk, img_valid, busy}
  localparam int ST_BUSY     = 0;
  localparam int ST_VALID    = 1;
  localparam int ST_ERR_CHK  = 2;
  localparam int ST_ERR_CMD  = 3;
  localparam int ST_ERR_OVR  = 4;
  localparam int ST_ERR_TO   = 5;
  localparam int ST_STATE_LO = 6;

  // The first bit on the wire (MSB) lands on the lowest pixel index.
  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/spi_img_timeout.sv
// Inactivity counter: cleared on activity, counts while enabled and
// saturates at TIMEOUT_CYC-1, where expired stays high until cleared.
module spi_img_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt;

  // Count idle cycles; hold at the limit so the count never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr)             cnt <= '0;
    else if (en && !expired)    cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/spi_image_loader.sv
// SPI image loader: decodes the command byte stream from the SPI
// peripheral, assembles an IMG_W x IMG_H binary image and hands it to the
// inference core with a valid/ack handshake. Optional trailing XOR
// checksum byte is enabled by defining SPI_IMG_CHECKSUM_EN.
module spi_image_loader
  import spi_img_pkg::*;
#(
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [IMG_W*IMG_H-1:0]   img_bits,
  output logic                     img_valid,
  input  logic                     img_ack,
  output logic                     busy,
  output logic [7:0]               status
);

  localparam int NPIX      = IMG_W * IMG_H;
  localparam int IMG_BYTES = NPIX / 8;
  localparam int CW        = (IMG_BYTES > 1) ? $clog2(IMG_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMG_BYTES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] byte_cnt;
  logic [CW+2:0] bit_base;
  logic          err_timeout, err_overrun, err_cmd, err_chk;
  logic          expired;
  logic          last_byte;
  logic          is_load, is_clear;

  assign bit_base  = {byte_cnt, 3'b000};
  assign last_byte = (byte_cnt == LAST);
  assign is_load   = (rx_data == CMD_LOAD);
  assign is_clear  = (rx_data == CMD_CLEAR);

  // Timer runs only while a transfer is in flight and no byte arrives.
  spi_img_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (!busy || rx_valid),
    .en      (busy && !rx_valid),
    .expired (expired)
  );

`ifdef SPI_IMG_CHECKSUM_EN
  logic [7:0] xor_acc;

  // Running XOR of the payload and the checksum-mismatch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      xor_acc <= '0;
      err_chk <= 1'b0;
    end else if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (is_load) xor_acc <= '0;
          if (is_load || is_clear) err_chk <= 1'b0;
        end
        LOAD:    xor_acc <= xor_acc ^ rx_data;
        CHK:     if (rx_data != xor_acc) err_chk <= 1'b1;
        default: ;
      endcase
    end
  end
`else
  assign err_chk = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rx_valid && is_load) state_d = LOAD;
      LOAD: begin
        if (rx_valid) begin
`ifdef SPI_IMG_CHECKSUM_EN
          if (last_byte) state_d = CHK;
`else
          if (last_byte) state_d = DONE;
`endif
        end else if (expired) begin
          state_d = IDLE;
        end
      end
`ifdef SPI_IMG_CHECKSUM_EN
      CHK: begin
        if (rx_valid)     state_d = (rx_data == xor_acc) ? DONE : IDLE;
        else if (expired) state_d = IDLE;
      end
`endif
      DONE:    if (img_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs and status byte.
  always_comb begin
    busy      = (state_q == LOAD) || (state_q == CHK);
    img_valid = (state_q == DONE);
    status    = '0;
    status[ST_STATE_LO +: 2] = state_q;
    status[ST_ERR_TO]  = err_timeout;
    status[ST_ERR_OVR] = err_overrun;
    status[ST_ERR_CMD] = err_cmd;
    status[ST_ERR_CHK] = err_chk;
    status[ST_VALID]   = img_valid;
    status[ST_BUSY]    = busy;
  end

  // Image buffer, byte counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      img_bits    <= '0;
      byte_cnt    <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      err_cmd     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (rx_valid) begin
          if (is_load) begin
            byte_cnt    <= '0;
            err_timeout <= 1'b0;
            err_cmd     <= 1'b0;
          end else if (is_clear) begin
            img_bits    <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            err_cmd     <= 1'b0;
          end else begin
            err_cmd     <= 1'b1;
          end
        end
        LOAD: begin
          if (rx_valid) begin
            img_bits[bit_base +: 8] <= bitrev8(rx_data);
            if (!last_byte) byte_cnt <= byte_cnt + 1'b1;
          end else if (expired) begin
            err_timeout <= 1'b1;
          end
        end
        CHK:  if (!rx_valid && expired) err_timeout <= 1'b1;
        DONE: if (rx_valid) err_overrun <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
